scc_wave_engine: RTL and testbench



---
 rtl/scc_wave_engine_pkg.sv | 44 ++++
 rtl/scc_wave_engine_if.sv | 19 +
 rtl/scc_wave_channel.sv | 55 +++++
 rtl/scc_wave_engine.sv | 208 ++++++++++++++++++++
 tb/tb_scc_wave_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scc_wave_engine_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scc_wave_pkg : register map helpers and constants for scc_wave_engine
// Revision 1.0
// ----------------------------------------------------------------------------
package scc_wave_pkg;

  localparam int PRESCALE        = 6;
  localparam int HALT_THRESH     = 8;
  localparam int MODE_SHARED_BIT = 0;
  localparam int MODE_PHRST_BIT  = 1;

  typedef enum logic [2:0] {
    REG_NONE    = 3'd0,
    REG_WAVE    = 3'd1,
    REG_FREQ_LO = 3'd2,
    REG_FREQ_HI = 3'd3,
    REG_VOL     = 3'd4,
    REG_ENABLE  = 3'd5,
    REG_MODE    = 3'd6
  } reg_sel_e;

  function automatic int wave_off(int wave_depth, int ch, int idx);
    return ch * wave_depth + idx;
  endfunction

  function automatic int freq_off(int ch_num, int wave_depth, int ch, bit hi);
    return ch_num * wave_depth + 2 * ch + int'(hi);
  endfunction

  function automatic int vol_off(int ch_num, int wave_depth, int ch);
    return ch_num * wave_depth + 2 * ch_num + ch;
  endfunction

  function automatic int enable_off(int ch_num, int wave_depth);
    return ch_num * wave_depth + 3 * ch_num;
  endfunction

  function automatic int mode_off(int ch_num, int wave_depth);
    return enable_off(ch_num, wave_depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scc_wave_engine_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scc_wave_if : single-cycle request / one-cycle acknowledge register bus
// Revision 1.0
// ----------------------------------------------------------------------------
interface scc_wave_if #(
  parameter int ADR_BITS = 8
);
  logic                req;
  logic                wrt;
  logic [ADR_BITS-1:0] adr;
  logic [7:0]          dbo;
  logic                ack;
  logic [7:0]          dbi;

  modport master (output req, wrt, adr, dbo, input ack, dbi);
  modport slave  (input req, wrt, adr, dbo, output ack, dbi);
endinterface
`default_nettype wire

// File: rtl/scc_wave_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scc_wave_channel : per-channel frequency down-counter and wave phase
// Revision 1.0
// ----------------------------------------------------------------------------
module scc_wave_channel #(
  parameter int WAVE_DEPTH = 32,
  parameter int FREQ_BITS  = 12
) (
  input  wire logic                          clk21m,
  input  wire logic                          nreset,
  input  wire logic                          tick,
  input  wire logic [FREQ_BITS-1:0]          freq,
  input  wire logic [FREQ_BITS-1:0]          freq_new,
  input  wire logic                          phase_rst,
  output logic [$clog2(WAVE_DEPTH)-1:0]      phase
);
  import scc_wave_pkg::*;

  localparam int PH_BITS = $clog2(WAVE_DEPTH);

  logic [FREQ_BITS-1:0] cnt_q, cnt_d;
  logic [PH_BITS-1:0]   phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    // A phase-reset freq write wins over a tick landing on the same edge.
    if (phase_rst) begin
      cnt_d   = freq_new;
      phase_d = '0;
    end else if (tick && (freq > FREQ_BITS'(HALT_THRESH))) begin
      if (cnt_q == '0) begin
        cnt_d   = freq;
        phase_d = phase_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk21m) begin
    if (!nreset) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/scc_wave_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scc_wave_engine : multi-channel wavetable engine with time-multiplexed mixer
// Revision 1.0
// ----------------------------------------------------------------------------
module scc_wave_engine #(
  parameter int CH_NUM     = 5,
  parameter int WAVE_DEPTH = 32,
  parameter int FREQ_BITS  = 12,
  parameter int VOL_BITS   = 4,
  parameter int ADR_BITS   = 8,
  parameter int OUT_BITS   = 8 + VOL_BITS + $clog2(CH_NUM)
) (
  input  wire logic                 clk21m,
  input  wire logic                 nreset,
  scc_wave_if.slave                 bus,
  output logic signed [OUT_BITS-1:0] wavl
);
  import scc_wave_pkg::*;

  localparam int CH_BITS    = $clog2(CH_NUM);
  localparam int PH_BITS    = $clog2(WAVE_DEPTH);
  localparam int MEM_ABITS  = CH_BITS + PH_BITS;
  localparam int MEM_WORDS  = CH_NUM * WAVE_DEPTH;
  localparam int SLOT_BITS  = $clog2(CH_NUM + 1);
  localparam int PRESC_BITS = $clog2(PRESCALE);
  localparam int W_BASE     = wave_off(WAVE_DEPTH, CH_NUM, 0);
  localparam logic [CH_BITS-1:0] LAST_CH   = CH_BITS'(CH_NUM - 1);
  localparam logic [CH_BITS-1:0] SHARE_SRC = CH_BITS'(CH_NUM - 2);

  logic [FREQ_BITS-1:0] freq_q [CH_NUM];
  logic [FREQ_BITS-1:0] freq_d [CH_NUM];
  logic [VOL_BITS-1:0]  vol_q  [CH_NUM];
  logic [VOL_BITS-1:0]  vol_d  [CH_NUM];
  logic [CH_NUM-1:0]    enable_q, enable_d;
  logic [1:0]           mode_q, mode_d;
  logic                 ack_q, ack_d;
  logic [7:0]           dbi_q, dbi_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic signed [OUT_BITS-1:0] acc_q, acc_d;
  logic signed [OUT_BITS-1:0] wavl_q, wavl_d;
  logic [7:0]           wave_mem_q [MEM_WORDS];

  int                   adr_i;
  reg_sel_e             sel;
  logic [CH_BITS-1:0]   sel_ch;
  logic                 shared;
  logic [MEM_ABITS-1:0] wave_raddr;
  logic                 wave_we;
  logic [7:0]           rd_data;
  logic [CH_NUM-1:0]    phase_rst;
  logic [PH_BITS-1:0]   phase [CH_NUM];
  logic                 tick;

  logic [CH_BITS-1:0]   ch_sel;
  logic [CH_BITS-1:0]   mix_src;
  logic [7:0]           sample;
  logic signed [OUT_BITS-1:0] sample_ext, vol_ext, prod;

  assign shared = mode_q[MODE_SHARED_BIT];

  always_comb begin
    adr_i  = int'(bus.adr);
    sel    = REG_NONE;
    sel_ch = '0;
    if (adr_i < W_BASE) begin
      sel    = REG_WAVE;
      sel_ch = bus.adr[MEM_ABITS-1:PH_BITS];
    end
    for (int c = 0; c < CH_NUM; c++) begin
      if (adr_i == freq_off(CH_NUM, WAVE_DEPTH, c, 1'b0)) begin
        sel    = REG_FREQ_LO;
        sel_ch = CH_BITS'(c);
      end
      if (adr_i == freq_off(CH_NUM, WAVE_DEPTH, c, 1'b1)) begin
        sel    = REG_FREQ_HI;
        sel_ch = CH_BITS'(c);
      end
      if (adr_i == vol_off(CH_NUM, WAVE_DEPTH, c)) begin
        sel    = REG_VOL;
        sel_ch = CH_BITS'(c);
      end
    end
    if (adr_i == enable_off(CH_NUM, WAVE_DEPTH)) sel = REG_ENABLE;
    if (adr_i == mode_off(CH_NUM, WAVE_DEPTH))   sel = REG_MODE;
  end

  // In shared mode the last channel's wave window aliases channel CH_NUM-2.
  always_comb begin
    wave_raddr = bus.adr[MEM_ABITS-1:0];
    if (shared && (sel_ch == LAST_CH)) wave_raddr = {SHARE_SRC, bus.adr[PH_BITS-1:0]};
    wave_we = bus.req && bus.wrt && (sel == REG_WAVE) && !(shared && (sel_ch == LAST_CH));
  end

  always_comb begin
    freq_d    = freq_q;
    vol_d     = vol_q;
    enable_d  = enable_q;
    mode_d    = mode_q;
    ack_d     = bus.req;
    dbi_d     = dbi_q;
    phase_rst = '0;
    case (sel)
      REG_WAVE:    rd_data = wave_mem_q[wave_raddr];
      REG_FREQ_LO: rd_data = freq_q[sel_ch][7:0];
      REG_FREQ_HI: rd_data = 8'(freq_q[sel_ch][FREQ_BITS-1:8]);
      REG_VOL:     rd_data = 8'(vol_q[sel_ch]);
      REG_ENABLE:  rd_data = 8'(enable_q);
      REG_MODE:    rd_data = 8'(mode_q);
      default:     rd_data = 8'hFF;
    endcase
    if (bus.req && bus.wrt) begin
      case (sel)
        REG_FREQ_LO: begin
          freq_d[sel_ch][7:0] = bus.dbo;
          phase_rst[sel_ch]   = mode_q[MODE_PHRST_BIT];
        end
        REG_FREQ_HI: begin
          freq_d[sel_ch][FREQ_BITS-1:8] = bus.dbo[FREQ_BITS-9:0];
          phase_rst[sel_ch]             = mode_q[MODE_PHRST_BIT];
        end
        REG_VOL:    vol_d[sel_ch] = bus.dbo[VOL_BITS-1:0];
        REG_ENABLE: enable_d      = bus.dbo[CH_NUM-1:0];
        REG_MODE:   mode_d        = bus.dbo[1:0];
        default:    ;
      endcase
    end
    if (bus.req && !bus.wrt) dbi_d = rd_data;
  end

  assign tick = (presc_q == PRESC_BITS'(PRESCALE - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    scc_wave_channel #(
      .WAVE_DEPTH (WAVE_DEPTH),
      .FREQ_BITS  (FREQ_BITS)
    ) u_ch (
      .clk21m    (clk21m),
      .nreset    (nreset),
      .tick      (tick),
      .freq      (freq_q[c]),
      .freq_new  (freq_d[c]),
      .phase_rst (phase_rst[c]),
      .phase     (phase[c])
    );
  end

  always_comb begin
    ch_sel     = slot_q[CH_BITS-1:0];
    mix_src    = (shared && (ch_sel == LAST_CH)) ? SHARE_SRC : ch_sel;
    sample     = wave_mem_q[{mix_src, phase[ch_sel]}];
    sample_ext = {{(OUT_BITS-8){sample[7]}}, sample};
    vol_ext    = {{(OUT_BITS-VOL_BITS){1'b0}}, vol_q[ch_sel]};
    prod       = sample_ext * vol_ext;
    slot_d     = slot_q + 1'b1;
    acc_d      = acc_q;
    wavl_d     = wavl_q;
    if (slot_q == SLOT_BITS'(CH_NUM)) begin
      slot_d = '0;
      wavl_d = acc_q;
      acc_d  = '0;
    end else if (enable_q[ch_sel]) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk21m) begin
    if (!nreset) begin
      freq_q   <= '{default: '0};
      vol_q    <= '{default: '0};
      enable_q <= '0;
      mode_q   <= '0;
      ack_q    <= 1'b0;
      dbi_q    <= '0;
      presc_q  <= '0;
      slot_q   <= '0;
      acc_q    <= '0;
      wavl_q   <= '0;
    end else begin
      freq_q   <= freq_d;
      vol_q    <= vol_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      ack_q    <= ack_d;
      dbi_q    <= dbi_d;
      presc_q  <= presc_d;
      slot_q   <= slot_d;
      acc_q    <= acc_d;
      wavl_q   <= wavl_d;
    end
  end

  // Wave RAM is not reset; a same-edge mixer read sees the old word.
  always_ff @(posedge clk21m) begin
    if (nreset && wave_we) wave_mem_q[bus.adr[MEM_ABITS-1:0]] <= bus.dbo;
  end

  assign bus.ack = ack_q;
  assign bus.dbi = dbi_q;
  assign wavl    = wavl_q;

endmodule
`default_nettype wire

// File: tb/tb_scc_wave_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_scc_wave_engine : self-checking bench for scc_wave_engine
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scc_wave_engine;
  localparam int CH   = 5;
  localparam int WD   = 32;
  localparam int FB   = 12;
  localparam int VB   = 4;
  localparam int AB   = 8;
  localparam int OB   = 8 + VB + $clog2(CH);
  localparam int W    = CH * WD;
  localparam int VOLB = W + 2 * CH;
  localparam int EN   = W + 3 * CH;
  localparam int MODE = EN + 1;

  logic clk21m = 1'b0;
  logic nreset = 1'b0;
  logic signed [OB-1:0] wavl;

  scc_wave_if #(.ADR_BITS(AB)) bus ();

  scc_wave_engine #(
    .CH_NUM(CH), .WAVE_DEPTH(WD), .FREQ_BITS(FB), .VOL_BITS(VB),
    .ADR_BITS(AB), .OUT_BITS(OB)
  ) dut (
    .clk21m (clk21m),
    .nreset (nreset),
    .bus    (bus),
    .wavl   (wavl)
  );

  always #5 clk21m = ~clk21m;

  int checks   = 0;
  int failures = 0;

  int mem_m  [W];
  int freq_m [CH];
  int vol_m  [CH];
  int en_m, mode_m;

  typedef struct {
    bit do_wr;
    int adr;
    int wdata;
    int exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void model_clear_regs();
    for (int c = 0; c < CH; c++) begin
      freq_m[c] = 0;
      vol_m[c]  = 0;
    end
    en_m   = 0;
    mode_m = 0;
  endfunction

  function automatic void model_write(input int a, input int d);
    int c;
    if (a < W) begin
      c = a / WD;
      if (!((mode_m & 1) != 0 && c == CH - 1)) mem_m[a] = d & 'hFF;
    end else if (a < W + 2 * CH) begin
      c = (a - W) / 2;
      if ((a - W) % 2 == 0) freq_m[c] = (freq_m[c] & 'hF00) | (d & 'hFF);
      else                  freq_m[c] = (freq_m[c] & 'hFF) | ((d & 'hF) << 8);
    end else if (a < EN) begin
      vol_m[a - VOLB] = d & 'hF;
    end else if (a == EN) begin
      en_m = d & 'h1F;
    end else if (a == MODE) begin
      mode_m = d & 3;
    end
  endfunction

  function automatic int model_read(input int a);
    int c;
    int i;
    if (a < W) begin
      c = a / WD;
      i = a % WD;
      if ((mode_m & 1) != 0 && c == CH - 1) c = CH - 2;
      return mem_m[c * WD + i];
    end else if (a < W + 2 * CH) begin
      c = (a - W) / 2;
      if ((a - W) % 2 == 0) return freq_m[c] & 'hFF;
      return (freq_m[c] >> 8) & 'hF;
    end else if (a < EN) begin
      return vol_m[a - VOLB];
    end else if (a == EN) begin
      return en_m;
    end else if (a == MODE) begin
      return mode_m;
    end
    return 'hFF;
  endfunction

  // All phases sit at 0 here because every channel frequency is halted.
  function automatic int model_wavl();
    int sum = 0;
    int src;
    int s;
    for (int c = 0; c < CH; c++) begin
      if (((en_m >> c) & 1) != 0) begin
        src = ((mode_m & 1) != 0 && c == CH - 1) ? CH - 2 : c;
        s = mem_m[src * WD];
        if (s >= 128) s = s - 256;
        sum = sum + s * vol_m[c];
      end
    end
    return sum;
  endfunction

  task automatic bus_write(input int a, input int d);
    @(negedge clk21m);
    bus.req = 1'b1;
    bus.wrt = 1'b1;
    bus.adr = AB'(a);
    bus.dbo = 8'(d);
    @(posedge clk21m);
    #1;
    bus.req = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input int a, output logic [31:0] d, output logic [31:0] pulse);
    @(negedge clk21m);
    bus.req = 1'b1;
    bus.wrt = 1'b0;
    bus.adr = AB'(a);
    @(posedge clk21m);
    #1;
    d     = {24'b0, bus.dbi};
    pulse = {31'b0, bus.ack};
    bus.req = 1'b0;
    @(posedge clk21m);
    #1;
    if (bus.ack !== 1'b0) pulse = 32'd2;
  endtask

  task automatic wait_wavl(input string name, input int exp, input int budget);
    int n = 0;
    while (n < budget && $signed(wavl) !== OB'(exp)) begin
      @(posedge clk21m);
      #1;
      n++;
    end
    check(name, $signed(wavl), exp);
  endtask

  task automatic wait_change(input int budget, output int delta, output logic signed [31:0] val);
    logic signed [OB-1:0] w0;
    w0    = wavl;
    delta = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk21m);
      #1;
      if (wavl !== w0) begin
        delta = i;
        break;
      end
    end
    val = $signed(wavl);
  endtask

  logic [31:0] rd, pl;
  logic signed [31:0] val;
  int delta;
  int changes;
  int ra;

  initial begin
    #9_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0;
    bus.wrt = 1'b0;
    bus.adr = '0;
    bus.dbo = '0;
    model_clear_regs();
    for (int i = 0; i < W; i++) mem_m[i] = 0;

    vecs[0] = '{1'b1, VOLB,     'hFF, 'h0F};
    vecs[1] = '{1'b1, W + 1,    'hFF, 'h0F};
    vecs[2] = '{1'b1, W,        'hA5, 'hA5};
    vecs[3] = '{1'b1, EN,       'hFF, 'h1F};
    vecs[4] = '{1'b1, MODE,     'hFF, 'h03};
    vecs[5] = '{1'b1, MODE,     'h00, 'h00};
    vecs[6] = '{1'b1, MODE + 1, 'h12, 'hFF};
    vecs[7] = '{1'b0, 'hFF,     'h00, 'hFF};
    vecs[8] = '{1'b1, W + 9,    'h3C, 'h0C};
    vecs[9] = '{1'b1, VOLB + 4, 'h07, 'h07};

    repeat (3) @(posedge clk21m);
    #1;
    check("reset_wavl", $signed(wavl), 0);
    check("reset_ack", {31'b0, bus.ack}, 0);
    check("reset_dbi", {24'b0, bus.dbi}, 0);
    @(negedge clk21m);
    nreset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].adr, vecs[i].wdata);
      bus_read(vecs[i].adr, rd, pl);
      check($sformatf("vec%0d_dbi", i), rd, vecs[i].exp);
      check($sformatf("vec%0d_ack", i), pl, 1);
    end

    // wave RAM read-back and single-cycle ack
    for (int i = 0; i < 32; i++) bus_write(i, (i < 16) ? 'h7F : 'h00);
    bus_read('h00, rd, pl);
    check("wave_rd_00", rd, 'h7F);
    check("wave_rd_00_ack", pl, 1);
    bus_read('h10, rd, pl);
    check("wave_rd_10", rd, 'h00);
    check("wave_rd_10_ack", pl, 1);

    // single channel full-scale output
    for (int i = 16; i < 32; i++) bus_write(i, 'h7F);
    bus_write(VOLB, 15);
    bus_write(W, 'hFE);
    bus_write(W + 1, 'h00);
    bus_write(EN, 'h01);
    wait_wavl("ch0_full_scale", 1905, 12);

    // ramp table makes wavl equal to ch0's phase
    for (int i = 0; i < 32; i++) bus_write(i, i);
    bus_write(VOLB, 1);
    bus_write(MODE, 'h02);
    bus_write(W, 'hFE);
    repeat (12) @(posedge clk21m);
    #1;
    check("fe_phase_reset", $signed(wavl), 0);
    wait_change(1700, delta, val);
    check("fe_first_step", val, 1);
    wait_change(1700, delta, val);
    check("fe_period", delta, 1530);
    check("fe_second_step", val, 2);

    // freq at the halt threshold freezes the phase
    bus_write(W, 8);
    repeat (12) @(posedge clk21m);
    #1;
    check("halt_phase", $signed(wavl), 0);
    changes = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk21m);
      #1;
      if ($signed(wavl) != 0) changes++;
    end
    check("halt_changes", changes, 0);
    bus_write(W, 9);
    wait_change(100, delta, val);
    check("f9_first_step", val, 1);
    wait_change(100, delta, val);
    check("f9_period_a", delta, 60);
    check("f9_step_a", val, 2);
    wait_change(100, delta, val);
    check("f9_period_b", delta, 60);

    // mid-period freq write with phase-reset mode
    repeat (20) @(posedge clk21m);
    #1;
    check("midperiod_before", $signed(wavl), 3);
    bus_write(W, 9);
    repeat (12) @(posedge clk21m);
    #1;
    check("midperiod_reset", $signed(wavl), 0);

    // shared mode aliasing of the last channel's wave window
    bus_write((CH - 2) * WD + 3, 'hA3);
    bus_write(MODE, 'h01);
    bus_write((CH - 1) * WD + 3, 'h55);
    bus_read((CH - 1) * WD + 3, rd, pl);
    check("shared_read", rd, model_read((CH - 1) * WD + 3));
    bus_write(MODE, 'h00);
    bus_write((CH - 1) * WD + 3, 'h55);
    bus_read((CH - 1) * WD + 3, rd, pl);
    check("unshared_read", rd, model_read((CH - 1) * WD + 3));

    // all channels at most-negative sample and full volume
    for (int i = 0; i < W; i++) bus_write(i, 'h80);
    for (int c = 0; c < CH; c++) bus_write(VOLB + c, 15);
    bus_write(EN, 'h1F);
    wait_wavl("all_min", -9600, 12);

    // reset during a pending read request
    @(negedge clk21m);
    nreset  = 1'b0;
    bus.req = 1'b1;
    bus.wrt = 1'b0;
    bus.adr = 8'h00;
    @(posedge clk21m);
    #1;
    bus.req = 1'b0;
    check("midrun_reset_wavl", $signed(wavl), 0);
    check("midrun_reset_ack", {31'b0, bus.ack}, 0);
    check("midrun_reset_dbi", {24'b0, bus.dbi}, 0);
    @(posedge clk21m);
    #1;
    check("midrun_reset_ack2", {31'b0, bus.ack}, 0);
    model_clear_regs();
    @(negedge clk21m);
    nreset = 1'b1;

    // randomized register/RAM traffic against the reference model
    for (int it = 0; it < 20; it++) begin
      for (int c = 0; c < CH; c++) bus_write(c * WD, $urandom_range(0, 255));
      for (int k = 0; k < 4; k++) bus_write($urandom_range(0, W - 1), $urandom_range(0, 255));
      for (int c = 0; c < CH; c++) bus_write(VOLB + c, $urandom_range(0, 255));
      bus_write(EN, $urandom_range(0, 255));
      bus_write(MODE, $urandom_range(0, 1));
      for (int k = 0; k < 3; k++) begin
        ra = $urandom_range(0, 255);
        bus_read(ra, rd, pl);
        check($sformatf("rand_rd_%0d", ra), rd, model_read(ra));
      end
      repeat (12) @(posedge clk21m);
      #1;
      check($sformatf("rand_wavl_%0d", it), $signed(wavl), model_wavl());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
